// File: rtl/psg_pkg.sv
// Shared constants and types for the dual-PSG CPU bus controller.
// Builds with TURBOSOUND_EN use the SEL_* codes to switch between two PSGs.
package psg_pkg;

  localparam logic [2:0] MODE_INACT = 3'b000;
  localparam logic [2:0] MODE_LATCH = 3'b111;
  localparam logic [2:0] MODE_WRITE = 3'b110;
  localparam logic [2:0] MODE_READ  = 3'b011;

  // Only A15, A14 and A1 take part in port matching.
  localparam logic [15:0] PORT_MASK      = 16'hC002;
  localparam logic [15:0] PORT_FFFD_VAL  = 16'hC000;
  localparam logic [15:0] PORT_BFFD_VAL  = 16'h8000;

  localparam logic [7:0] SEL_PSG0 = 8'hFF;
  localparam logic [7:0] SEL_PSG1 = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/psg_port_decode.sv
// Combinational match of the CPU port address against the two PSG ports.
module psg_port_decode
  import psg_pkg::*;
(
  input  logic [15:0] addr_i,
  output logic        is_fffd_o,
  output logic        is_bffd_o
);

  assign is_fffd_o = (addr_i & PORT_MASK) == PORT_FFFD_VAL;
  assign is_bffd_o = (addr_i & PORT_MASK) == PORT_BFFD_VAL;

endmodule

// File: rtl/psg_bus_ctrl.sv
// CPU-to-PSG bus controller: one strobe per CPU I/O write, combinational reads.
// Define TURBOSOUND_EN to enable the second PSG, selected by writing FE/FF to FFFD.
module psg_bus_ctrl
  import psg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iorq_ni,
  input  logic        rd_ni,
  input  logic        wr_ni,
  input  logic [15:0] addr_i,
  input  logic [7:0]  cpu_di_i,
  output logic [7:0]  cpu_do_o,
  output logic        cpu_oe_o,
  output logic [7:0]  psg_di_o,
  output logic [2:0]  psg0_mode_o,
  output logic [2:0]  psg1_mode_o,
  input  logic [7:0]  psg0_do_i,
  input  logic [7:0]  psg1_do_i,
  output logic        psg_sel_o
);

  state_e     state_q, state_d;
  logic       iorq_q;
  logic [7:0] psg_di_q, psg_di_d;
  logic       to_addr_q, to_addr_d;
  logic       is_fffd, is_bffd;
  logic       acc_start, wr_start, rd_active, sel_cmd, psg_sel;
  logic [2:0] mode;

  psg_port_decode u_decode (
    .addr_i    (addr_i),
    .is_fffd_o (is_fffd),
    .is_bffd_o (is_bffd)
  );

  assign acc_start = iorq_q & ~iorq_ni & (rd_ni ^ wr_ni);
  assign wr_start  = acc_start & ~wr_ni & (is_fffd | is_bffd);
  // Gated by reset so the read path cannot drive the bus while held in reset.
  assign rd_active = rst_ni & ~iorq_ni & ~rd_ni & is_fffd;

`ifdef TURBOSOUND_EN
  logic psg_sel_q, psg_sel_d;

  assign sel_cmd = to_addr_q & ((psg_di_q == SEL_PSG0) | (psg_di_q == SEL_PSG1));
  assign psg_sel = psg_sel_q;

  always_comb begin
    psg_sel_d = psg_sel_q;
    if (state_q == ST_IDLE && wr_start && is_fffd) begin
      if (cpu_di_i == SEL_PSG1) psg_sel_d = 1'b1;
      else if (cpu_di_i == SEL_PSG0) psg_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) psg_sel_q <= 1'b0;
    else         psg_sel_q <= psg_sel_d;
  end
`else
  assign sel_cmd = 1'b0;
  assign psg_sel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psg_di_d  = psg_di_q;
    to_addr_d = to_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_start) begin
          state_d   = ST_STROBE;
          psg_di_d  = cpu_di_i;
          to_addr_d = is_fffd;
        end
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD:   if (iorq_ni) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      iorq_q    <= 1'b0;
      psg_di_q  <= 8'h00;
      to_addr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iorq_q    <= iorq_ni;
      psg_di_q  <= psg_di_d;
      to_addr_q <= to_addr_d;
    end
  end

  always_comb begin
    mode     = MODE_INACT;
    cpu_do_o = 8'hFF;
    cpu_oe_o = 1'b0;
    if (state_q == ST_STROBE) begin
      if (!to_addr_q)   mode = MODE_WRITE;
      else if (!sel_cmd) mode = MODE_LATCH;
    end else if (rd_active) begin
      mode     = MODE_READ;
      cpu_do_o = psg_sel ? psg1_do_i : psg0_do_i;
      cpu_oe_o = 1'b1;
    end
  end

  assign psg0_mode_o = psg_sel ? MODE_INACT : mode;
`ifdef TURBOSOUND_EN
  assign psg1_mode_o = psg_sel ? mode : MODE_INACT;
`else
  assign psg1_mode_o = MODE_INACT;
`endif
  assign psg_di_o  = psg_di_q;
  assign psg_sel_o = psg_sel;

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// Self-checking bench for psg_bus_ctrl: directed scenarios plus random bus traffic
// against a transaction-level model. Define TURBOSOUND_EN to also cover PSG switching.
module tb_psg_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iorq_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  cpu_di, psg0_do, psg1_do;
  logic [7:0]  cpu_do, psg_di;
  logic        cpu_oe, psg_sel;
  logic [2:0]  psg0_mode, psg1_mode;

  int n_checks = 0;
  int n_err    = 0;
  int n_latch0, n_write0, n_latch1, n_write1, n_read;
  logic [7:0] latch_di, write_di;

  // Model: an accepted write produces a strobe on the next cycle, then the
  // controller stays busy until iorq_n is seen high again.
  bit       m_prev_hi, m_strobe, m_busy, m_to_addr, m_selcmd, m_sel;
  logic [7:0] m_di;

  always #5 clk = ~clk;

  psg_bus_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .iorq_ni     (iorq_n),
    .rd_ni       (rd_n),
    .wr_ni       (wr_n),
    .addr_i      (addr),
    .cpu_di_i    (cpu_di),
    .cpu_do_o    (cpu_do),
    .cpu_oe_o    (cpu_oe),
    .psg_di_o    (psg_di),
    .psg0_mode_o (psg0_mode),
    .psg1_mode_o (psg1_mode),
    .psg0_do_i   (psg0_do),
    .psg1_do_i   (psg1_do),
    .psg_sel_o   (psg_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit dec_fffd(input logic [15:0] a);
    return a[15] && a[14] && !a[1];
  endfunction

  function automatic bit dec_bffd(input logic [15:0] a);
    return a[15] && !a[14] && !a[1];
  endfunction

  task automatic model_reset();
    m_prev_hi = 0; m_strobe = 0; m_busy = 0; m_to_addr = 0;
    m_selcmd = 0;  m_sel = 0;    m_di = 8'h00;
  endtask

  task automatic model_step();
    bit start;
    start = m_prev_hi && !iorq_n && (rd_n != wr_n);
    if (m_strobe) begin
      m_strobe = 0;
      m_busy   = 1;
    end else if (m_busy) begin
      if (iorq_n) m_busy = 0;
    end else if (start && !wr_n && (dec_fffd(addr) || dec_bffd(addr))) begin
      m_strobe  = 1;
      m_to_addr = dec_fffd(addr);
      m_di      = cpu_di;
      m_selcmd  = 0;
`ifdef TURBOSOUND_EN
      if (m_to_addr && (cpu_di == 8'hFE || cpu_di == 8'hFF)) begin
        m_selcmd = 1;
        m_sel    = (cpu_di == 8'hFE);
      end
`endif
    end
    m_prev_hi = iorq_n;
  endtask

  task automatic check_outputs();
    logic [2:0] mv, e0, e1;
    logic [7:0] edo;
    logic       eoe;
    mv = 3'b000; edo = 8'hFF; eoe = 1'b0;
    if (m_strobe) mv = m_to_addr ? (m_selcmd ? 3'b000 : 3'b111) : 3'b110;
    else if (!iorq_n && !rd_n && dec_fffd(addr)) begin
      mv  = 3'b011;
      edo = m_sel ? psg1_do : psg0_do;
      eoe = 1'b1;
    end
    e0 = m_sel ? 3'b000 : mv;
    e1 = m_sel ? mv : 3'b000;
    check("modes", {psg0_mode, psg1_mode}, {e0, e1});
    check("read", {cpu_do, cpu_oe}, {edo, eoe});
    check("bus", {psg_di, psg_sel}, {m_di, m_sel});
  endtask

  task automatic count_strobes();
    if (psg0_mode == 3'b111) begin n_latch0++; latch_di = psg_di; end
    if (psg0_mode == 3'b110) begin n_write0++; write_di = psg_di; end
    if (psg1_mode == 3'b111) n_latch1++;
    if (psg1_mode == 3'b110) n_write1++;
    if (cpu_oe) n_read++;
  endtask

  task automatic clear_counts();
    n_latch0 = 0; n_write0 = 0; n_latch1 = 0; n_write1 = 0; n_read = 0;
  endtask

  task automatic cyc(input bit io, input bit r, input bit w,
                     input logic [15:0] a, input logic [7:0] d);
    iorq_n = io; rd_n = r; wr_n = w; addr = a; cpu_di = d;
    @(negedge clk);
    check_outputs();
    count_strobes();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    cyc(1, 1, 1, a, d);
    repeat (3) cyc(0, 1, 0, a, d);
    cyc(1, 1, 1, a, d);
  endtask

  task automatic io_read(input logic [15:0] a);
    cyc(1, 1, 1, a, 8'h00);
    repeat (3) cyc(0, 0, 1, a, 8'h00);
    cyc(1, 1, 1, a, 8'h00);
  endtask

  initial begin
    logic [15:0] ra;
    bit          rio;
    rst_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 16'h0000; cpu_di = 8'h00; psg0_do = 8'h00; psg1_do = 8'h00;
    latch_di = 8'h00; write_di = 8'h00;
    model_reset();
    clear_counts();

    #3;
    check("rst_modes", {psg0_mode, psg1_mode}, 6'b000000);
    check("rst_read", {cpu_do, cpu_oe}, {8'hFF, 1'b0});
    check("rst_bus", {psg_di, psg_sel}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;

    // Address latch then data write on PSG0
    clear_counts();
    io_write(16'hFFFD, 8'h07);
    io_write(16'hBFFD, 8'h3E);
    check("seq_latch_cnt", n_latch0, 1);
    check("seq_write_cnt", n_write0, 1);
    check("seq_latch_di", latch_di, 8'h07);
    check("seq_write_di", write_di, 8'h3E);
    check("seq_psg1_quiet", n_latch1 + n_write1, 0);

    // Don't-care address bits still decode
    clear_counts();
    io_write(16'hC13C, 8'h0A);
    io_write(16'h8F01, 8'hA5);
    io_write(16'h7FFD, 8'h99);
    io_write(16'hFFFF, 8'h98);
    check("dc_latch_cnt", n_latch0, 1);
    check("dc_write_cnt", n_write0, 1);

    // Read path
    psg0_do = 8'h5A; psg1_do = 8'hC3;
    clear_counts();
    io_read(16'hFFFD);
    check("rd_cycles", n_read, 3);
    check("rd_after", {cpu_do, cpu_oe}, {8'hFF, 1'b0});
    io_read(16'hBFFD);
    check("rd_bffd_none", n_read, 3);

    // Long write cycle: one strobe only
    clear_counts();
    cyc(1, 1, 1, 16'hBFFD, 8'h11);
    repeat (10) cyc(0, 1, 0, 16'hBFFD, 8'h11);
    cyc(1, 1, 1, 16'hBFFD, 8'h11);
    check("long_write_cnt", n_write0, 1);

    // rd_n and wr_n both low: ignored
    clear_counts();
    cyc(1, 1, 1, 16'hFFFD, 8'h22);
    repeat (5) cyc(0, 0, 0, 16'hFFFD, 8'h22);
    cyc(1, 1, 1, 16'hFFFD, 8'h22);
    check("both_low_cnt", n_latch0 + n_write0, 0);

    // Reset in the middle of a strobe
    cyc(1, 1, 1, 16'hBFFD, 8'h55);
    cyc(0, 1, 0, 16'hBFFD, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    check("rst_strobe_modes", {psg0_mode, psg1_mode}, 6'b000000);
    check("rst_strobe_bus", {psg_di, psg_sel, cpu_oe}, {8'h00, 1'b0, 1'b0});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    clear_counts();
    repeat (4) cyc(0, 1, 0, 16'hBFFD, 8'h55);
    check("no_replay", n_write0, 0);
    io_write(16'hBFFD, 8'h66);
    check("post_rst_write", n_write0, 1);

`ifdef TURBOSOUND_EN
    clear_counts();
    io_write(16'hFFFD, 8'hFE);
    check("ts_sel1", psg_sel, 1'b1);
    check("ts_no_strobe", n_latch0 + n_write0 + n_latch1 + n_write1, 0);
    io_write(16'hFFFD, 8'h08);
    io_write(16'hBFFD, 8'h0F);
    check("ts_psg1_latch", n_latch1, 1);
    check("ts_psg1_write", n_write1, 1);
    check("ts_psg0_quiet", n_latch0 + n_write0, 0);
    io_read(16'hFFFD);
    io_write(16'hFFFD, 8'hFF);
    check("ts_sel0", psg_sel, 1'b0);
`endif

    // Random traffic
    rio = 1'b1;
    ra  = 16'hFFFD;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rio = ~rio;
        case ($urandom_range(0, 4))
          0, 1:    ra = 16'hFFFD;
          2:       ra = 16'hBFFD;
          default: ra = 16'($urandom);
        endcase
      end
      psg0_do = 8'($urandom);
      psg1_do = 8'($urandom);
      cyc(rio, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
          ($urandom_range(0, 3) == 0) ? 8'($urandom_range(254, 255)) : 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/psg_bus_ctrl.md
PSG_BUS_CTRL -- requirements
Module: psg_bus_ctrl

Interface
REQ-001 SHALL have clock  in  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have iorq_n, rd_n, wr_n  in  1 each  CPU I/O strobes, synchronous to clock, active-low.
REQ-004 SHALL have addr  in  16  CPU port address.
REQ-005 SHALL have cpu_di  in  8  CPU write data.
REQ-006 SHALL have cpu_do  out  8  read data returned to the CPU.
REQ-007 SHALL have cpu_oe  out  1  high while cpu_do drives a PSG read.
REQ-008 SHALL have psg_di  out  8  data/address bus to both PSGs.
REQ-009 SHALL have psg0_mode, psg1_mode  out  3 each  {bdir,bc2,bc1} per PSG.
REQ-010 SHALL have psg0_do, psg1_do  in  8 each  PSG read data.
REQ-011 SHALL have psg_sel  out  1  currently selected PSG (0 or 1).

Function
REQ-012 SHALL decode port FFFD as A15=1, A14=1, A1=0 (register select / read), and BFFD as A15=1, A14=0, A1=0 (data write); other address bits are don't-care.
REQ-013 SHALL detect an access start as iorq_n sampled high on the previous cycle and low now, with exactly one of rd_n, wr_n low; rd_n and wr_n both low SHALL be ignored.
REQ-014 SHALL run FSM IDLE -> STROBE -> HOLD -> IDLE; STROBE is entered on the cycle after a decoded write start and lasts exactly one cycle.
REQ-015 SHALL capture cpu_di at the write start and drive it on psg_di during STROBE; psg_di otherwise holds its last value.
REQ-016 In STROBE, write to FFFD SHALL drive mode 111 (latch address), and write to BFFD SHALL drive mode 110 (write register), on the selected PSG only.
REQ-017 HOLD SHALL remain until iorq_n is sampled high, so one CPU cycle produces exactly one strobe.
REQ-018 A read of FFFD SHALL drive mode 011 on the selected PSG combinationally while iorq_n=0 and rd_n=0, with cpu_do = selected psgN_do and cpu_oe=1.
REQ-019 Outside REQ-016/REQ-018, both mode outputs SHALL be 000, cpu_oe=0, and cpu_do=FF.
REQ-020 The unselected PSG SHALL always see mode 000.
REQ-021 A new access start while in STROBE or HOLD SHALL be ignored.

Reset
REQ-022 reset low SHALL force IDLE, psg_sel=0, psg_di=00, both modes 000, cpu_oe=0 and cpu_do=FF, immediately and regardless of clock; an in-flight strobe is aborted and not replayed.

Configuration
REQ-023 Macro TURBOSOUND_EN: when defined, a write of FF to FFFD SHALL set psg_sel=0 and FE SHALL set psg_sel=1, taking effect in STROBE with modes 000 (no address latch). When undefined, psg_sel SHALL be constant 0, psg1_mode SHALL be constant 000, and FE/FF SHALL be latched as ordinary register addresses.

Structure
REQ-024 Package psg_pkg SHALL hold the mode constants (INACT 000, LATCH 111, WRITE 110, READ 011), port match masks/values, the select codes FE/FF, and the FSM state typedef.
REQ-025 Port decoding SHALL be a combinational sub-module psg_port_decode (addr -> is_fffd, is_bffd); the FSM and muxing stay in psg_bus_ctrl.

Verification
REQ-026 Write FFFD=07 then BFFD=3E: expect one cycle psg0_mode=111 with psg_di=07, then one cycle psg0_mode=110 with psg_di=3E; psg1_mode stays 000.
REQ-027 With TURBOSOUND_EN, write FFFD=FE then FFFD=08, BFFD=0F: expect psg_sel=1, no strobe for FE, and strobes 111/08 then 110/0F on psg1 only.
REQ-028 Read FFFD with psg0_do=5A and psg_sel=0: expect psg0_mode=011, cpu_do=5A and cpu_oe=1 while rd_n low; FF and 0 after.
REQ-029 Hold iorq_n and wr_n low for 10 cycles on BFFD: expect exactly one 110 strobe; rd_n and wr_n both low gives no strobe.
REQ-030 Assert reset during STROBE: expect modes 000 the same cycle, psg_sel=0, and no strobe after release until a new access start.
